// File: rtl/pri_icache_ctrl_slave.sv
// Cache-side responder for the private icache control bus: bypass/flush handshakes,
// fetch drain + tag invalidation walk sequencing, and saturating perf counters.
// All outputs registered; invalidate walk advances one set per granted cycle.
module pri_icache_ctrl_slave #(
   parameter int NB_SETS   = 32,
   parameter int CNT_WIDTH = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       bypass_req_i,
   output logic                       bypass_ack_o,
   input  logic                       flush_req_i,
   output logic                       flush_ack_o,
   input  logic                       ctrl_clear_regs_i,
   input  logic                       ctrl_enable_regs_i,
   output logic [CNT_WIDTH-1:0]       ctrl_hit_count_o,
   output logic [CNT_WIDTH-1:0]       ctrl_trans_count_o,
   output logic [CNT_WIDTH-1:0]       ctrl_miss_count_o,
   input  logic                       evt_trans_i,
   input  logic                       evt_hit_i,
   input  logic                       evt_miss_i,
   input  logic                       fetch_idle_i,
   output logic                       fetch_block_o,
   output logic                       cache_bypass_o,
   output logic                       tag_inv_req_o,
   output logic [$clog2(NB_SETS)-1:0] tag_inv_set_o,
   input  logic                       tag_inv_gnt_i
);

   localparam int SW = $clog2(NB_SETS);
   localparam logic [SW-1:0] LAST_SET = SW'(NB_SETS - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, INVAL, FLUSH_DONE} state_e;
   // Operation latched on leaving IDLE; requests seen later do not alter it.
   typedef enum logic [1:0] {OP_FLUSH, OP_ENTER, OP_LEAVE} op_e;

   state_e         state_q;
   op_e            op_q;
   logic           fetch_block_q;
   logic           cache_bypass_q;
   logic           bypass_ack_q;
   logic           flush_ack_q;
   logic           tag_inv_req_q;
   logic [SW-1:0]  set_q;

   // Control FSM: drain fetches, optionally walk all sets, then complete the handshake.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         op_q           <= OP_FLUSH;
         fetch_block_q  <= 1'b0;
         cache_bypass_q <= 1'b0;
         bypass_ack_q   <= 1'b0;
         flush_ack_q    <= 1'b0;
         tag_inv_req_q  <= 1'b0;
         set_q          <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               // Flush has priority; a deferred mode change is picked up on a later visit.
               if (flush_req_i && !flush_ack_q) begin
                  op_q          <= OP_FLUSH;
                  fetch_block_q <= 1'b1;
                  state_q       <= DRAIN;
               end else if (bypass_req_i != bypass_ack_q) begin
                  op_q          <= bypass_req_i ? OP_ENTER : OP_LEAVE;
                  fetch_block_q <= 1'b1;
                  state_q       <= DRAIN;
               end
            end
            DRAIN: begin
               if (fetch_idle_i) begin
                  if (op_q == OP_ENTER) begin
                     // Bypass does not read the arrays, so no invalidation is needed.
                     cache_bypass_q <= 1'b1;
                     bypass_ack_q   <= 1'b1;
                     fetch_block_q  <= 1'b0;
                     state_q        <= IDLE;
                  end else begin
                     tag_inv_req_q <= 1'b1;
                     set_q         <= '0;
                     state_q       <= INVAL;
                  end
               end
            end
            INVAL: begin
               if (tag_inv_gnt_i) begin
                  if (set_q == LAST_SET) begin
                     set_q         <= '0;
                     tag_inv_req_q <= 1'b0;
                     fetch_block_q <= 1'b0;
                     if (op_q == OP_FLUSH) begin
                        flush_ack_q <= 1'b1;
                        state_q     <= FLUSH_DONE;
                     end else begin
                        cache_bypass_q <= 1'b0;
                        bypass_ack_q   <= 1'b0;
                        state_q        <= IDLE;
                     end
                  end else begin
                     set_q <= set_q + SW'(1);
                  end
               end
            end
            FLUSH_DONE: begin
               if (!flush_req_i) begin
                  flush_ack_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign fetch_block_o  = fetch_block_q;
   assign cache_bypass_o = cache_bypass_q;
   assign bypass_ack_o   = bypass_ack_q;
   assign flush_ack_o    = flush_ack_q;
   assign tag_inv_req_o  = tag_inv_req_q;
   assign tag_inv_set_o  = set_q;

   // Counter index: 0 = trans, 1 = hit, 2 = miss.
   logic [CNT_WIDTH-1:0] cnt_q [3];
   logic [CNT_WIDTH-1:0] cnt_d [3];
   logic [2:0]           evt;

   assign evt = {evt_miss_i, evt_hit_i, evt_trans_i};

   // Next counter values: clear beats increment, increments stop at all-ones.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i];
         if (ctrl_clear_regs_i) begin
            cnt_d[i] = '0;
         end else if (ctrl_enable_regs_i && evt[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}})) begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign ctrl_trans_count_o = cnt_q[0];
   assign ctrl_hit_count_o   = cnt_q[1];
   assign ctrl_miss_count_o  = cnt_q[2];

endmodule

// File: tb/tb_pri_icache_ctrl_slave.sv
// Bench for pri_icache_ctrl_slave: directed scenarios with literal expectations
// plus a cycle-by-cycle check of counters and walk index against a reference model.
module tb_pri_icache_ctrl_slave;

   localparam int NSETS = 32;
   localparam int CMAX  = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic       bypass_req, flush_req, clr, en;
   logic       ev_trans, ev_hit, ev_miss, fetch_idle, gnt;
   logic       bypass_ack, flush_ack, fetch_block, cache_bypass, inv_req;
   logic [3:0] hit_cnt, trans_cnt, miss_cnt;
   logic [4:0] inv_set;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   int m_hit, m_trans, m_miss, m_set;

   pri_icache_ctrl_slave #(.NB_SETS(NSETS), .CNT_WIDTH(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .bypass_req_i(bypass_req), .bypass_ack_o(bypass_ack),
      .flush_req_i(flush_req), .flush_ack_o(flush_ack),
      .ctrl_clear_regs_i(clr), .ctrl_enable_regs_i(en),
      .ctrl_hit_count_o(hit_cnt), .ctrl_trans_count_o(trans_cnt), .ctrl_miss_count_o(miss_cnt),
      .evt_trans_i(ev_trans), .evt_hit_i(ev_hit), .evt_miss_i(ev_miss),
      .fetch_idle_i(fetch_idle), .fetch_block_o(fetch_block), .cache_bypass_o(cache_bypass),
      .tag_inv_req_o(inv_req), .tag_inv_set_o(inv_set), .tag_inv_gnt_i(gnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat_add(input int v, input logic e);
      int r;
      r = v + int'(e);
      return (r > CMAX) ? CMAX : r;
   endfunction

   // Model compare on the falling edge, then advance the model for the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         m_hit = 0; m_trans = 0; m_miss = 0; m_set = 0;
      end else begin
         if (inv_req) chk("model_set", 32'(inv_set), 32'(m_set));
         chk("model_hit", 32'(hit_cnt), 32'(m_hit));
         chk("model_trans", 32'(trans_cnt), 32'(m_trans));
         chk("model_miss", 32'(miss_cnt), 32'(m_miss));
         if (clr) begin
            m_hit = 0; m_trans = 0; m_miss = 0;
         end else if (en) begin
            m_hit   = sat_add(m_hit, ev_hit);
            m_trans = sat_add(m_trans, ev_trans);
            m_miss  = sat_add(m_miss, ev_miss);
         end
         if (inv_req && gnt) m_set = (m_set + 1) % NSETS;
      end
   end

   // Walk from set 0 with grant held high, ending one edge after the last grant.
   task automatic walk_full(input string tag);
      for (int i = 0; i < NSETS; i++) begin
         chk({tag, "_req"}, 32'(inv_req), 1);
         chk({tag, "_set"}, 32'(inv_set), i);
         tick();
      end
      chk({tag, "_req_end"}, 32'(inv_req), 0);
      chk({tag, "_blk_end"}, 32'(fetch_block), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bypass_req = 0; flush_req = 0; clr = 0; en = 0;
      ev_trans = 0; ev_hit = 0; ev_miss = 0; fetch_idle = 0; gnt = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      chk("rst_block", 32'(fetch_block), 0);
      chk("rst_bypass", 32'(cache_bypass), 0);
      chk("rst_back", 32'(bypass_ack), 0);
      chk("rst_fack", 32'(flush_ack), 0);
      chk("rst_req", 32'(inv_req), 0);
      chk("rst_set", 32'(inv_set), 0);
      chk("rst_hit", 32'(hit_cnt), 0);

      // Flush, grant tied high
      fetch_idle = 1; gnt = 1; flush_req = 1;
      tick();
      chk("fl_block", 32'(fetch_block), 1);
      chk("fl_noreq", 32'(inv_req), 0);
      tick();
      walk_full("fl");
      chk("fl_ack", 32'(flush_ack), 1);
      tick();
      chk("fl_ack_hold", 32'(flush_ack), 1);
      flush_req = 0;
      tick();
      chk("fl_ack_drop", 32'(flush_ack), 0);

      // Enter bypass with a 5-cycle drain
      fetch_idle = 0; bypass_req = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("by_drain_ack", 32'(bypass_ack), 0);
         chk("by_drain_blk", 32'(fetch_block), 1);
         chk("by_drain_req", 32'(inv_req), 0);
      end
      fetch_idle = 1;
      tick();
      chk("by_ack", 32'(bypass_ack), 1);
      chk("by_mode", 32'(cache_bypass), 1);
      chk("by_unblk", 32'(fetch_block), 0);
      chk("by_noinv", 32'(inv_req), 0);

      // Leave bypass: full invalidation walk
      bypass_req = 0;
      tick();
      chk("lv_block", 32'(fetch_block), 1);
      chk("lv_ack_hold", 32'(bypass_ack), 1);
      tick();
      walk_full("lv");
      chk("lv_ack", 32'(bypass_ack), 0);
      chk("lv_mode", 32'(cache_bypass), 0);

      // Flush and bypass together: flush completes first
      flush_req = 1; bypass_req = 1;
      tick();
      chk("both_block", 32'(fetch_block), 1);
      tick();
      walk_full("both");
      chk("both_fack", 32'(flush_ack), 1);
      chk("both_back_wait", 32'(bypass_ack), 0);
      flush_req = 0;
      tick();
      chk("both_fack_drop", 32'(flush_ack), 0);
      tick();
      chk("both_by_block", 32'(fetch_block), 1);
      chk("both_by_pending", 32'(bypass_ack), 0);
      tick();
      chk("both_by_ack", 32'(bypass_ack), 1);
      chk("both_by_mode", 32'(cache_bypass), 1);
      bypass_req = 0;
      for (int k = 0; k < 100 && bypass_ack; k++) tick();
      chk("both_leave_done", 32'(bypass_ack), 0);
      chk("both_leave_mode", 32'(cache_bypass), 0);

      // Grant stalled 3 cycles on set 7
      flush_req = 1;
      tick();
      tick();
      for (int i = 0; i < 7; i++) begin
         chk("st_set", 32'(inv_set), i);
         tick();
      end
      gnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_hold_set", 32'(inv_set), 7);
         chk("st_hold_req", 32'(inv_req), 1);
      end
      gnt = 1;
      tick();
      chk("st_resume", 32'(inv_set), 8);
      for (int k = 0; k < 60 && !flush_ack; k++) tick();
      chk("st_fack", 32'(flush_ack), 1);
      flush_req = 0;
      tick();
      chk("st_fack_drop", 32'(flush_ack), 0);

      // Counters: saturation, clear priority, enable gating
      en = 1;
      for (int i = 0; i < 20; i++) begin
         ev_hit = 1; ev_trans = (i < 5); ev_miss = (i < 2);
         tick();
      end
      ev_hit = 0; ev_trans = 0; ev_miss = 0;
      chk("cnt_hit_sat", 32'(hit_cnt), 15);
      chk("cnt_trans", 32'(trans_cnt), 5);
      chk("cnt_miss", 32'(miss_cnt), 2);
      clr = 1; ev_hit = 1; ev_trans = 1;
      tick();
      clr = 0; ev_trans = 0;
      chk("cnt_clr_hit", 32'(hit_cnt), 0);
      chk("cnt_clr_trans", 32'(trans_cnt), 0);
      en = 0;
      repeat (3) tick();
      chk("cnt_dis", 32'(hit_cnt), 0);
      en = 1;
      repeat (3) tick();
      ev_hit = 0;
      chk("cnt_en3", 32'(hit_cnt), 3);
      en = 0;

      // Asynchronous reset in the middle of a walk
      flush_req = 1;
      tick();
      tick();
      repeat (10) tick();
      chk("rw_set10", 32'(inv_set), 10);
      #2 rst = 1'b1;
      #1;
      chk("rw_req", 32'(inv_req), 0);
      chk("rw_set", 32'(inv_set), 0);
      chk("rw_block", 32'(fetch_block), 0);
      chk("rw_fack", 32'(flush_ack), 0);
      chk("rw_hit", 32'(hit_cnt), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick();
      chk("rw_redrain", 32'(fetch_block), 1);
      tick();
      chk("rw_restart_req", 32'(inv_req), 1);
      chk("rw_restart_set", 32'(inv_set), 0);
      for (int k = 0; k < 60 && !flush_ack; k++) tick();
      chk("rw_fack", 32'(flush_ack), 1);
      flush_req = 0;
      tick();
      chk("rw_fack_drop", 32'(flush_ack), 0);

      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
